// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the host-side BLE command link.
package remote_comm_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        SEND_HI,
        SEND_LO
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_POS  = 8'h5A;

    localparam int DEF_BAUD_DIV = 434;

endpackage

// File: rtl/remote_comm_tx.sv
// Single 8N1 frame shifter; a load in the done cycle chains frames gap-free.
module uart_byte_tx
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       TX,
    output logic       done
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          active_q, active_d;

    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        active_d = active_q;
        done     = active_q && (bit_q == 4'd9) && (baud_q == '0);
        if (load) begin
            tx_d     = 1'b0;
            shift_d  = {1'b1, byte_in};
            bit_d    = 4'd0;
            baud_d   = BAUD_LAST;
            active_d = 1'b1;
        end else if (active_q) begin
            if (baud_q != '0) begin
                baud_d = baud_q - CW'(1);
            end else if (done) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[8:1]};
                bit_d   = bit_q + 4'd1;
                baud_d  = BAUD_LAST;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            active_q <= active_d;
        end
    end

    assign TX = tx_q;

endmodule

// File: rtl/remote_comm.sv
// Host end of the robot UART link: 16-bit command out as two frames,
// single-byte responses in.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_sent,
    output logic        tx_busy,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);

    tx_state_t     tx_state_q, tx_state_d;
    logic [15:0]   hold_q, hold_d;
    logic          go_q, go_d;
    logic          busy_q, busy_d;
    logic          sent_q, sent_d;
    logic [CW-1:0] guard_q, guard_d;
    logic          byte_load, byte_done;
    logic [7:0]    byte_data;

    uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load    (byte_load),
        .byte_in (byte_data),
        .TX      (TX),
        .done    (byte_done)
    );

    // guard keeps TX idle for a bit time after reset
    always_comb begin
        tx_state_d = tx_state_q;
        hold_d     = hold_q;
        go_d       = 1'b0;
        busy_d     = busy_q;
        sent_d     = sent_q;
        guard_d    = guard_q;
        byte_load  = go_q || ((tx_state_q == SEND_HI) && byte_done);
        byte_data  = go_q ? hold_q[15:8] : hold_q[7:0];
        if (guard_q != '0) guard_d = guard_q - CW'(1);
        if (go_q) begin
            busy_d = 1'b1;
            sent_d = 1'b0;
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (snd_cmd && guard_q == '0) begin
                    hold_d     = cmd;
                    go_d       = 1'b1;
                    tx_state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (byte_done) tx_state_d = SEND_LO;
            end
            SEND_LO: begin
                if (byte_done) begin
                    busy_d     = 1'b0;
                    sent_d     = 1'b1;
                    tx_state_d = TX_IDLE;
                    if (snd_cmd) begin
                        hold_d     = cmd;
                        go_d       = 1'b1;
                        tx_state_d = SEND_HI;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    rx_state_t     rx_state_q, rx_state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    resp_q, resp_d;
    logic          rdy_q, rdy_d;

    // a start is only real once its mid-bit sample reads low
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        resp_d     = resp_q;
        rdy_d      = rdy_q;
        if (clr_resp_rdy) rdy_d = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = BAUD_HALF;
                end
            end
            RX_START: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else if (sync2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = BAUD_LAST;
                    rx_bit_d   = 3'd0;
                    rdy_d      = 1'b0;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else begin
                    rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
                    rx_cnt_d = BAUD_LAST;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else begin
                    rx_state_d = RX_IDLE;
                    if (sync2_q) begin
                        resp_d = rx_sh_q;
                        rdy_d  = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            hold_q     <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            guard_q    <= BAUD_FULL;
            rx_state_q <= RX_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            resp_q     <= 8'h00;
            rdy_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            hold_q     <= hold_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            guard_q    <= guard_d;
            rx_state_q <= rx_state_d;
            sync1_q    <= RX;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            resp_q     <= resp_d;
            rdy_q      <= rdy_d;
        end
    end

    assign cmd_sent = sent_q;
    assign tx_busy  = busy_q;
    assign resp     = resp_q;
    assign resp_rdy = rdy_q;

endmodule
